// File: rtl/lacc_fmap_responder.sv
// Line-buffer fetch responder: walks a row-major feature-map tile,
// issues SRAM reads and returns words in order under credit gating.
module lacc_fmap_responder #(
    parameter int BUFFER_WIDTH    = 32,
    parameter int BUFFER_DEPTH    = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int XW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1,
    localparam int YW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    input  logic [XW-1:0]         buffer_width_i,
    input  logic [YW-1:0]         buffer_depth_i,
    output logic                  busy,
    output logic                  done,
    input  logic                  lacc_data_valid,
    output logic                  lacc_data_ready,
    output logic                  lacc_drsp_valid,
    output logic [31:0]           lacc_drsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_rdata
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [XW-1:0]         x, last_x;
    logic [YW-1:0]         y, last_y;
    logic [ADDR_WIDTH-1:0] cur_addr, row_addr, stride;
    logic [CW-1:0]         inflight;

    logic [31:0]           fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    logic start_acc, credit_ok, hsk, x_end, last_hsk;
    logic push, pop, fifo_empty, fifo_wr, fifo_rd;

    assign start_acc  = start & (state == IDLE);
    assign credit_ok  = inflight < CW'(MAX_OUTSTANDING);
    assign hsk        = lacc_data_valid & lacc_data_ready;
    assign x_end      = (x == last_x);
    assign last_hsk   = hsk & x_end & (y == last_y);
    assign mem_req_addr = cur_addr;

    // Abandoned reads returning after a reset must not reach the consumer.
    assign push       = mem_rsp_valid & (state != IDLE);
    assign fifo_empty = (count == '0);
    assign fifo_wr    = push & ~fifo_empty;
    assign fifo_rd    = ~fifo_empty;
    assign pop        = fifo_rd | push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_acc) state_nx = RUN;
            RUN:     if (last_hsk) state_nx = DRAIN;
            DRAIN:   if (inflight == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lacc_data_ready = 1'b0;
        mem_req_valid   = 1'b0;
        busy            = (state != IDLE);
        if (state == RUN) begin
            lacc_data_ready = credit_ok & mem_req_ready;
            mem_req_valid   = lacc_data_valid & credit_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) & (inflight == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            last_x   <= '0;
            last_y   <= '0;
            stride   <= '0;
            cur_addr <= '0;
            row_addr <= '0;
        end else if (start_acc) begin
            x        <= '0;
            y        <= '0;
            last_x   <= buffer_width_i;
            last_y   <= buffer_depth_i;
            stride   <= row_stride_i;
            cur_addr <= base_addr_i;
            row_addr <= base_addr_i;
        end else if (hsk) begin
            if (!x_end) begin
                x        <= x + 1'b1;
                cur_addr <= cur_addr + ADDR_WIDTH'(4);
            end else begin
                x        <= '0;
                y        <= y + 1'b1;
                row_addr <= row_addr + stride;
                cur_addr <= row_addr + stride;
            end
        end
    end

    // The credit falls on the edge that registers the response word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({hsk, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= mem_rsp_rdata;
    end

    // An empty FIFO forwards the incoming word straight to the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            lacc_drsp_valid <= 1'b0;
            lacc_drsp_rdata <= '0;
        end else begin
            lacc_drsp_valid <= pop;
            if (pop) begin
                lacc_drsp_rdata <= fifo_empty ? mem_rsp_rdata
                                              : fifo_mem[rd_ptr];
            end
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end

endmodule

// File: tb/tb_lacc_fmap_responder.sv
// Directed bench for lacc_fmap_responder with a fixed-latency
// in-order memory model and a consumer that always requests.
module tb_lacc_fmap_responder;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW-1:0] row_stride_i = '0;
    logic [4:0]    buffer_width_i = '0;
    logic [2:0]    buffer_depth_i = '0;
    logic          busy, done;
    logic          lacc_data_valid = 1'b0;
    logic          lacc_data_ready;
    logic          lacc_drsp_valid;
    logic [31:0]   lacc_drsp_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [31:0]   mem_rsp_rdata = '0;

    int checks = 0;
    int errors = 0;

    int cyc = 0, lat = 1, rdy_mode = 0, total = 0;
    int nh = 0, nd = 0, max_out = 0, done_cnt = 0, done_cyc = 0;
    int first_hsk = 0, last_hsk = 0, first_drsp = 0, last_drsp = 0;
    bit bad_hsk, bad_bp, bad_credit;

    logic [AW-1:0] addr_q[$];
    logic [31:0]   data_q[$];
    int            pend_due[$];
    logic [31:0]   pend_dat[$];

    lacc_fmap_responder #(
        .BUFFER_WIDTH(32),
        .BUFFER_DEPTH(8),
        .ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr_i(base_addr_i),
        .row_stride_i(row_stride_i),
        .buffer_width_i(buffer_width_i),
        .buffer_depth_i(buffer_depth_i),
        .busy(busy),
        .done(done),
        .lacc_data_valid(lacc_data_valid),
        .lacc_data_ready(lacc_data_ready),
        .lacc_drsp_valid(lacc_drsp_valid),
        .lacc_drsp_rdata(lacc_drsp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Memory model and monitor: drive at negedge, sample just before posedge.
    always @(negedge clk) begin
        int nh_b;
        cyc++;
        mem_req_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pend_dat.pop_front();
            pend_due.delete(0);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
        end
        #3;
        if (lacc_drsp_valid) begin
            data_q.push_back(lacc_drsp_rdata);
            nd++;
            if (nd == 1) first_drsp = cyc;
            last_drsp = cyc;
        end
        nh_b = nh;
        if ((lacc_data_valid && lacc_data_ready) !==
            (mem_req_valid && mem_req_ready)) bad_hsk = 1'b1;
        if (lacc_data_ready && (nh_b - nd) >= 4) bad_credit = 1'b1;
        if (busy && nh_b < total && (nh_b - nd) < 4 &&
            lacc_data_ready !== mem_req_ready) bad_bp = 1'b1;
        if (lacc_data_valid && lacc_data_ready) begin
            if (!mem_req_ready) bad_bp = 1'b1;
            addr_q.push_back(mem_req_addr);
            if (nh == 0) first_hsk = cyc;
            last_hsk = cyc;
            nh++;
        end
        if (mem_req_valid && mem_req_ready) begin
            pend_due.push_back(cyc + lat);
            pend_dat.push_back(mdata(mem_req_addr));
        end
        if (nh - nd > max_out) max_out = nh - nd;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log(input int tot);
        nh = 0;
        nd = 0;
        max_out = 0;
        done_cnt = 0;
        bad_hsk = 1'b0;
        bad_bp = 1'b0;
        bad_credit = 1'b0;
        addr_q.delete();
        data_q.delete();
        total = tot;
    endtask

    task automatic run_tile(input string nm, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride, input int w,
                            input int d, input int l, input int mode,
                            input bit restart);
        int tot;
        int i;
        bit got;
        logic [AW-1:0] e;
        tot = (w + 1) * (d + 1);
        lat = l;
        rdy_mode = mode;
        clear_log(tot);
        @(negedge clk);
        start = 1'b1;
        base_addr_i = base;
        row_stride_i = stride;
        buffer_width_i = 5'(w);
        buffer_depth_i = 3'(d);
        lacc_data_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        if (restart) begin
            @(negedge clk);
            chk({nm, "_drain_busy"}, 32'(busy), 32'd1);
            start = 1'b1;
            base_addr_i = 16'h0080;
            buffer_width_i = 5'd3;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            #4;
            got = (done_cnt > 0);
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        #4;
        lacc_data_valid = 1'b0;
        chk({nm, "_nreq"}, nh, tot);
        chk({nm, "_nrsp"}, nd, tot);
        i = 0;
        for (int y = 0; y <= d; y++) begin
            for (int x = 0; x <= w; x++) begin
                e = base + AW'(y) * stride + AW'(4 * x);
                if (i < addr_q.size())
                    chk($sformatf("%s_addr%0d", nm, i), 32'(addr_q[i]), 32'(e));
                if (i < data_q.size())
                    chk($sformatf("%s_data%0d", nm, i), data_q[i], mdata(e));
                i++;
            end
        end
        chk({nm, "_done_once"}, done_cnt, 1);
        chk({nm, "_done_time"}, done_cyc, last_drsp + 1);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        chk({nm, "_hsk_match"}, 32'(bad_hsk), 32'd0);
        chk({nm, "_bp"}, 32'(bad_bp), 32'd0);
        chk({nm, "_credit"}, 32'(bad_credit), 32'd0);
        chk({nm, "_maxout"}, 32'(max_out <= 4), 32'd1);
        chk({nm, "_latency"}, first_drsp, first_hsk + l + 1);
        if (mode == 0 && l <= 3)
            chk({nm, "_thru"}, last_hsk - first_hsk, tot - 1);
    endtask

    initial begin
        bit got;
        int nd_b;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(lacc_data_ready), 0);
        chk("rst_drsp_valid", 32'(lacc_drsp_valid), 0);
        chk("rst_drsp_rdata", lacc_drsp_rdata, 0);
        chk("rst_mem_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_addr", 32'(mem_req_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        run_tile("basic", 16'h1000, 16'h0040, 3, 1, 2, 0, 1'b0);
        run_tile("stall", 16'h3000, 16'h0100, 7, 0, 8, 0, 1'b0);
        chk("stall_reach4", max_out, 4);
        run_tile("bp", 16'h2000, 16'h0080, 2, 2, 1, 1, 1'b0);
        run_tile("degen", 16'h0020, 16'h0000, 0, 0, 3, 0, 1'b1);
        run_tile("w0", 16'h0200, 16'h0100, 0, 2, 1, 0, 1'b0);
        run_tile("wrap", 16'hFFF8, 16'h0010, 3, 0, 2, 0, 1'b0);

        // Reset in the middle of a tile with reads still in flight.
        lat = 2;
        rdy_mode = 0;
        clear_log(8);
        @(negedge clk);
        start = 1'b1;
        base_addr_i = 16'h1000;
        row_stride_i = 16'h0040;
        buffer_width_i = 5'd7;
        buffer_depth_i = 3'd0;
        lacc_data_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            #4;
            got = (nh >= 3);
        end
        chk("mid_hsk3", 32'(got), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_ready", 32'(lacc_data_ready), 0);
        chk("mid_drsp_valid", 32'(lacc_drsp_valid), 0);
        chk("mid_drsp_rdata", lacc_drsp_rdata, 0);
        chk("mid_mem_valid", 32'(mem_req_valid), 0);
        chk("mid_mem_addr", 32'(mem_req_addr), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        #2 rst = 1'b0;
        nd_b = nd;
        repeat (6) @(negedge clk);
        #4;
        lacc_data_valid = 1'b0;
        chk("mid_no_drsp", nd - nd_b, 0);
        chk("mid_nreq", nh, 3);
        chk("mid_pend_empty", pend_due.size(), 0);

        run_tile("post_rst", 16'h1000, 16'h0040, 3, 1, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
